serializer: RTL
===============

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter DataWidth, default 8: width of one output beat in bits.
REQ-002 SHALL have parameter Ratio, default 4: number of output beats per input word; legal range 1..16.
REQ-003 SHALL have parameter LsbFirst, default 1: 1 = least significant slice emitted first; 0 = most significant slice first.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port data_i  input  DataWidth*Ratio  upstream wide word.
REQ-007 SHALL have port valid_i  input  1  upstream word valid.
REQ-008 SHALL have port ready_o  output  1  block accepts data_i this cycle.
REQ-009 SHALL have port valid_o  output  1  downstream beat valid.
REQ-010 SHALL have port data_o  output  DataWidth  downstream beat.
REQ-011 SHALL have port ready_i  input  1  downstream accepts beat this cycle.

Function
REQ-012 SHALL implement two states: IDLE (no word held) and SEND (word held, beats pending).
REQ-013 SHALL hold a word register of DataWidth*Ratio bits and a beat counter of max(1,$clog2(Ratio)) bits.
REQ-014 SHALL drive valid_o = 1 exactly when the state is SEND.
REQ-015 SHALL drive data_o = slice[idx] of the word register, where idx = count if LsbFirst=1, otherwise Ratio-1-count; slice k is bits [k*DataWidth +: DataWidth].
REQ-016 SHALL drive ready_o = 1 in IDLE, and in SEND only when count == Ratio-1 and ready_i == 1 (combinational path from ready_i).
REQ-017 In IDLE, valid_i=1 SHALL load data_i, clear count to 0, and enter SEND; the first beat is valid the next cycle (latency 1).
REQ-018 In SEND, ready_i=1 with count < Ratio-1 SHALL increment count.
REQ-019 In SEND, ready_i=1 with count == Ratio-1 and valid_i=1 SHALL load data_i, clear count, and remain in SEND (no bubble between words).
REQ-020 In SEND, ready_i=1 with count == Ratio-1 and valid_i=0 SHALL go to IDLE with count 0.
REQ-021 In SEND, ready_i=0 SHALL hold state, count, and the word register; data_o and valid_o stay stable.
REQ-022 The word register SHALL change only on an accepted input (valid_i && ready_o).
REQ-023 With Ratio=1 the block SHALL behave as a single-entry pipeline register: full throughput, one-cycle latency.
REQ-024 Sustained throughput SHALL be one beat per cycle while ready_i=1 and upstream keeps valid_i=1.

Reset
REQ-025 reset_ni=0 SHALL immediately force state IDLE, count 0, and word register 0, giving valid_o=0, ready_o=1, and data_o=0, independent of clk_i.
REQ-026 Reset asserted mid-word SHALL discard the remaining beats; the first word accepted after release SHALL start from beat 0.

Configuration
REQ-027 Macro SERIALIZER_LAST_EN defined SHALL add output port last_o (1 bit), equal to valid_o && (count == Ratio-1), with reset value 0.
REQ-028 Macro SERIALIZER_LAST_EN undefined SHALL omit last_o entirely; all other behaviour is identical.

Verification (DataWidth=8, Ratio=4, LsbFirst=1 unless stated)
REQ-029 Single word: data_i=0x44332211 with valid_i pulsed for one cycle from IDLE, ready_i=1 -> data_o 0x11, 0x22, 0x33, 0x44 on four consecutive cycles, then valid_o=0 and ready_o=1.
REQ-030 Back-to-back: 0x44332211 then 0x88776655 held on valid_i, ready_i=1 -> eight consecutive beats 0x11..0x88 with no gap; ready_o high only in the cycle showing 0x44 and the cycle showing 0x88.
REQ-031 Backpressure: ready_i=0 for 3 cycles while 0x22 is shown -> data_o=0x22 and valid_o=1 held for all 3 cycles; 0x33 follows once ready_i=1.
REQ-032 Reset mid-word: reset_ni driven low while 0x22 is shown -> valid_o=0 without a clock edge; after release, 0xDDCCBBAA yields 0xAA first.
REQ-033 LsbFirst=0: 0x44332211 -> beats 0x44, 0x33, 0x22, 0x11.
REQ-034 SERIALIZER_LAST_EN defined: 0x44332211 -> last_o=1 only while data_o=0x44 and valid_o=1.

Source files
------------

// File: rtl/serializer.sv
// Wide-to-narrow serializer: one DataWidth*Ratio word in, Ratio beats of DataWidth out (SERIALIZER_LAST_EN adds last_o).
// Latency: first beat valid one cycle after the word is accepted; back-to-back words need no bubble.
// Backpressure: ready_i=0 freezes the current beat; ready_o follows ready_i combinationally on the final beat.
module serializer #(
  parameter int DataWidth = 8,
  parameter int Ratio     = 4,
  parameter bit LsbFirst  = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [DataWidth*Ratio-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [DataWidth-1:0]       data_o,
  input  logic                       ready_i
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                       last_o
`endif
);

  localparam int CntW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state_q, state_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [DataWidth*Ratio-1:0] word_q, word_d;
  logic [CntW-1:0]            idx;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          word_d  = data_i;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (count_q == LastCnt) begin
            // Final beat leaving: accept the next word in the same cycle to avoid a bubble
            ready_o = 1'b1;
            count_d = '0;
            if (valid_i) begin
              word_d = data_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (LsbFirst) idx = count_q;
    else          idx = LastCnt - count_q;
  end

  assign valid_o = (state_q == SEND);
  assign data_o  = word_q[int'(idx)*DataWidth +: DataWidth];

`ifdef SERIALIZER_LAST_EN
  assign last_o = valid_o && (count_q == LastCnt);
`endif

endmodule
